buzzer_sequenciador: RTL

Controller that shares the single alarm buzzer among N_REQ alarm requesters, such as water level, temperature and feeding.
- Arbitrates by fixed priority; bit 0 is the highest.
- Plays a beep burst for the granted requester: requester i gets i+1 beeps.
- Drives the buzzer's liga/desliga inputs with single-cycle pulses.
- Handles mute/acknowledge (silencia) with per-requester masking until the request drops.
- Timing is counted in system ticks from the shared timebase.

---
 rtl/buzzer_sequenciador.sv | 124 ++++++++++++
 1 files changed

// File: rtl/buzzer_sequenciador.sv
// Shares one alarm buzzer among N_REQ requesters by fixed priority (bit 0 highest).
// Requester i gets a burst of i+1 beeps; liga/desliga are single-cycle pulses to the buzzer.
module buzzer_sequenciador #(
   parameter int N_REQ   = 3,
   parameter int T_ON    = 4,
   parameter int T_OFF   = 4,
   parameter int T_PAUSA = 16,
   parameter int W_CNT   = 8
) (
   input  logic             clock,
   input  logic             zera_n,
   input  logic             tick,
   input  logic [N_REQ-1:0] req,
   input  logic             silencia,
   output logic             liga,
   output logic             desliga,
   output logic [N_REQ-1:0] concedido,
   output logic             ocupado
);

   localparam int W_B = $clog2(N_REQ + 1);

   localparam logic [1:0] OCIOSO    = 2'd0;
   localparam logic [1:0] BIP       = 2'd1;
   localparam logic [1:0] INTERVALO = 2'd2;
   localparam logic [1:0] PAUSA     = 2'd3;

   logic [1:0]       state;
   logic [W_CNT-1:0] cnt;
   logic [W_B-1:0]   beeps;
   logic [W_B-1:0]   target;
   logic [N_REQ-1:0] mascara;
   logic [N_REQ-1:0] eleg;
   logic [N_REQ-1:0] grant_oh;
   logic [W_B-1:0]   grant_idx;

   assign eleg    = req & ~mascara;
   assign ocupado = (state != OCIOSO);

   // Descending scan so the lowest eligible index is the last one written.
   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (eleg[i]) begin
            grant_oh    = '0;
            grant_oh[i] = 1'b1;
            grant_idx   = W_B'(i);
         end
      end
   end

   always_ff @(posedge clock or negedge zera_n) begin
      if (!zera_n) begin
         state     <= OCIOSO;
         cnt       <= '0;
         beeps     <= '0;
         target    <= '0;
         mascara   <= '0;
         concedido <= '0;
         liga      <= 1'b0;
         desliga   <= 1'b0;
      end else begin
         liga    <= 1'b0;
         desliga <= 1'b0;
         // A mute masks whoever is asserting now; a mask bit lives only while its request stays high.
         mascara <= (mascara & req) | (silencia ? req : '0);
         case (state)
            OCIOSO: begin
               if (!silencia && (eleg != '0)) begin
                  concedido <= grant_oh;
                  target    <= grant_idx + W_B'(1);
                  cnt       <= '0;
                  beeps     <= '0;
                  liga      <= 1'b1;
                  state     <= BIP;
               end
            end
            default: begin
               if (silencia) begin
                  desliga   <= 1'b1;
                  state     <= OCIOSO;
                  concedido <= '0;
                  cnt       <= '0;
                  beeps     <= '0;
               end else if (tick) begin
                  case (state)
                     BIP: begin
                        if (cnt == W_CNT'(T_ON - 1)) begin
                           desliga <= 1'b1;
                           beeps   <= beeps + W_B'(1);
                           cnt     <= '0;
                           state   <= (beeps + W_B'(1) == target) ? PAUSA : INTERVALO;
                        end else begin
                           cnt <= cnt + W_CNT'(1);
                        end
                     end
                     INTERVALO: begin
                        if (cnt == W_CNT'(T_OFF - 1)) begin
                           liga  <= 1'b1;
                           cnt   <= '0;
                           state <= BIP;
                        end else begin
                           cnt <= cnt + W_CNT'(1);
                        end
                     end
                     PAUSA: begin
                        if (cnt == W_CNT'(T_PAUSA - 1)) begin
                           cnt       <= '0;
                           concedido <= '0;
                           state     <= OCIOSO;
                        end else begin
                           cnt <= cnt + W_CNT'(1);
                        end
                     end
                     default: state <= OCIOSO;
                  endcase
               end
            end
         endcase
      end
   end

endmodule
